// File: rtl/bank_arbiter_if.sv
// Bundle between the bank arbiter and its surroundings.
// Requester side : req_valid/req_we/req_row/req_col/req_wdata in, req_ready and
//                  rsp_valid/rsp_data/rsp_err/err_sticky out.
// Bank side      : mem_read_en/mem_write_en/mem_row/mem_col/mem_wdata out,
//                  mem_ack/mem_rdata in.
// Per-requester fields are packed, requester i at [i*W +: W].
// modport slave is the arbiter; modport master is the environment driving it.
interface bank_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int ROW_W  = 8,
  parameter int COL_W  = 6,
  parameter int DATA_W = 16
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_we;
  logic [N_REQ*ROW_W-1:0]  req_row;
  logic [N_REQ*COL_W-1:0]  req_col;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_data;
  logic                    rsp_err;
  logic                    err_sticky;
  logic                    mem_read_en;
  logic                    mem_write_en;
  logic [ROW_W-1:0]        mem_row;
  logic [COL_W-1:0]        mem_col;
  logic [DATA_W-1:0]       mem_wdata;
  logic                    mem_ack;
  logic [DATA_W-1:0]       mem_rdata;

  modport slave (
    input  req_valid, req_we, req_row, req_col, req_wdata, mem_ack, mem_rdata,
    output req_ready, rsp_valid, rsp_data, rsp_err, err_sticky,
           mem_read_en, mem_write_en, mem_row, mem_col, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_row, req_col, req_wdata, mem_ack, mem_rdata,
    input  req_ready, rsp_valid, rsp_data, rsp_err, err_sticky,
           mem_read_en, mem_write_en, mem_row, mem_col, mem_wdata
  );
endinterface

// File: rtl/bank_arbiter.sv
// Round-robin arbiter giving N_REQ requesters turns on one memory bank.
// One command is accepted per grant, held stable on the bank until ack (or
// watchdog timeout), answered with a one-cycle rsp_valid pulse, after which
// the finisher becomes lowest priority.
// Ports: clk_i (posedge), rst_i (asynchronous, active-high),
//        bus (bank_arbiter_if.slave) carrying requester and bank signals.
module bank_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ROW_W   = 8,
  parameter int COL_W   = 6,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic           clk_i,
  input  logic           rst_i,
  bank_arbiter_if.slave  bus
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, RELEASE} state_t;

  state_t              state_q;
  logic [IDX_W-1:0]    ptr_q;
  logic [IDX_W-1:0]    idx_q;
  logic                we_q;
  logic [ROW_W-1:0]    row_q;
  logic [COL_W-1:0]    col_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                rd_en_q;
  logic                wr_en_q;
  logic [N_REQ-1:0]    rsp_valid_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic                rsp_err_q;
  logic                err_sticky_q;

  logic                win_vld;
  logic [IDX_W-1:0]    win_idx;
  int                  scan_pos;

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    return {{(N_REQ-1){1'b0}}, 1'b1} << i;
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    if (i == IDX_W'(N_REQ-1)) return '0;
    return i + 1'b1;
  endfunction

  // Scan starts at ptr_q and wraps, so the first valid requester at or after
  // the pointer wins.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    scan_pos = 0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_pos = int'(ptr_q) + k;
      if (scan_pos >= N_REQ) scan_pos = scan_pos - N_REQ;
      if (!win_vld && bus.req_valid[scan_pos]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(scan_pos);
      end
    end
  end

  // Ready is combinational so a command is taken in the same cycle it is seen.
  assign bus.req_ready = (state_q == IDLE && win_vld && !rst_i) ? onehot(win_idx) : '0;

  assign bus.mem_read_en  = rd_en_q;
  assign bus.mem_write_en = wr_en_q;
  assign bus.mem_row      = row_q;
  assign bus.mem_col      = col_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.err_sticky   = err_sticky_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      idx_q        <= '0;
      we_q         <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            idx_q   <= win_idx;
            we_q    <= bus.req_we[win_idx];
            row_q   <= bus.req_row[win_idx*ROW_W +: ROW_W];
            col_q   <= bus.req_col[win_idx*COL_W +: COL_W];
            wdata_q <= bus.req_wdata[win_idx*DATA_W +: DATA_W];
            rd_en_q <= !bus.req_we[win_idx];
            wr_en_q <= bus.req_we[win_idx];
            cnt_q   <= '0;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          // Ack wins over the watchdog when both land on the same cycle.
          if (bus.mem_ack) begin
            rsp_data_q  <= bus.mem_rdata;
            rsp_err_q   <= 1'b0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            ptr_q       <= next_idx(idx_q);
            rsp_valid_q <= onehot(idx_q);
            state_q     <= RELEASE;
          end else if (cnt_q == CNT_W'(TIMEOUT-1)) begin
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b1;
            err_sticky_q <= 1'b1;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            ptr_q        <= next_idx(idx_q);
            rsp_valid_q  <= onehot(idx_q);
            state_q      <= RELEASE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        // Enables are low here, giving the bank a gap that ends its transaction.
        RELEASE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bank_arbiter.sv
module tb_bank_arbiter;
  localparam int N = 4, RW = 8, CW = 6, DW = 16, TO = 8;

  logic clk;
  logic rst;
  bank_arbiter_if #(.N_REQ(N), .ROW_W(RW), .COL_W(CW), .DATA_W(DW)) bus();

  bank_arbiter #(.N_REQ(N), .ROW_W(RW), .COL_W(CW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );

  typedef struct {
    int          idx;
    logic [15:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          checks;
  int          errors;
  int          cyc;

  // bank model state
  logic [15:0] mem [int];
  int          ack_delay;
  int          tx_cnt, tx_done;
  logic [7:0]  tx_row0;
  logic [5:0]  tx_col0;
  bit          tx_changed, tx_we_seen, tx_re_seen;
  int          last_cycles;
  logic [7:0]  last_row;
  bit          last_changed, last_we_seen, last_re_seen;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "simulation hung");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Bank model: acks on the ack_delay-th enabled cycle (0 = never) and
  // records what the bank saw during each transaction.
  initial begin
    int key;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    tx_cnt  = 0;
    tx_done = 0;
    forever begin
      @(negedge clk);
      if (bus.mem_read_en || bus.mem_write_en) begin
        if (tx_cnt == 0) begin
          tx_row0 = bus.mem_row;
          tx_col0 = bus.mem_col;
          tx_changed = 1'b0;
          tx_we_seen = 1'b0;
          tx_re_seen = 1'b0;
        end else if (bus.mem_row !== tx_row0 || bus.mem_col !== tx_col0) begin
          tx_changed = 1'b1;
        end
        tx_we_seen = tx_we_seen | bus.mem_write_en;
        tx_re_seen = tx_re_seen | bus.mem_read_en;
        tx_cnt++;
        if (ack_delay > 0 && tx_cnt == ack_delay) begin
          key = int'({bus.mem_row, bus.mem_col});
          bus.mem_rdata = mem.exists(key) ? mem[key] : 16'h0000;
          if (bus.mem_write_en) mem[key] = bus.mem_wdata;
          bus.mem_ack = 1'b1;
        end else begin
          bus.mem_ack = 1'b0;
        end
      end else begin
        if (tx_cnt != 0) begin
          last_cycles  = tx_cnt;
          last_row     = tx_row0;
          last_changed = tx_changed;
          last_we_seen = tx_we_seen;
          last_re_seen = tx_re_seen;
          tx_done++;
        end
        tx_cnt = 0;
        bus.mem_ack = 1'b0;
      end
    end
  end

  // Response monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.rsp_valid != '0) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: actual=%0h required=none", bus.rsp_valid);
        end else begin
          e = sb.pop_front();
          check("rsp_valid", {28'd0, bus.rsp_valid}, 32'd1 << e.idx);
          check("rsp_data", {16'd0, bus.rsp_data}, {16'd0, e.data});
          check("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
        end
      end
    end
  end

  task automatic push_exp(input int idx, input logic [15:0] data, input logic err);
    exp_t e;
    e.idx = idx;
    e.data = data;
    e.err = err;
    sb.push_back(e);
  endtask

  task automatic set_req(input int i, input logic we, input logic [7:0] row,
                         input logic [5:0] col, input logic [15:0] wd);
    bus.req_we[i] = we;
    bus.req_row[i*RW +: RW] = row;
    bus.req_col[i*CW +: CW] = col;
    bus.req_wdata[i*DW +: DW] = wd;
    bus.req_valid[i] = 1'b1;
  endtask

  task automatic wait_ready(output logic [3:0] r);
    r = '0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.req_ready != '0) begin
        r = bus.req_ready;
        break;
      end
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.mem_read_en && !bus.mem_write_en && tx_cnt == 0) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: actual=busy required=idle");
    end
  endtask

  task automatic step_in();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] r;
    int prev;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    ack_delay = 1;
    bus.req_valid = '0;
    bus.req_we = '0;
    bus.req_row = '0;
    bus.req_col = '0;
    bus.req_wdata = '0;
    for (int i = 0; i < N; i++) mem[int'({8'd10 + 8'(i), 6'd0})] = 16'h0100 + 16'(i);
    mem[int'({8'd5, 6'd8})] = 16'h00A5;
    mem[int'({8'd6, 6'd1})] = 16'h0077;

    // reset state, with requests pending
    repeat (2) @(negedge clk);
    bus.req_valid = 4'hF;
    #1;
    check("rst_ready", {28'd0, bus.req_ready}, 32'd0);
    check("rst_rsp_valid", {28'd0, bus.rsp_valid}, 32'd0);
    check("rst_read_en", {31'd0, bus.mem_read_en}, 32'd0);
    check("rst_write_en", {31'd0, bus.mem_write_en}, 32'd0);
    check("rst_sticky", {31'd0, bus.err_sticky}, 32'd0);
    check("rst_rsp_data", {16'd0, bus.rsp_data}, 32'd0);
    bus.req_valid = '0;
    step_in();
    rst = 1'b0;

    // all four valid, immediate ack: rotation 0,1,2,3,0 every 3 cycles
    step_in();
    ack_delay = 1;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 8'd10 + 8'(i), 6'd0, 16'h0);
    prev = 0;
    for (int g = 0; g < 5; g++) begin
      wait_ready(r);
      check("rr_grant", {28'd0, r}, 32'd1 << (g % 4));
      if (g > 0) check("rr_interval", cyc - prev, 32'd3);
      prev = cyc;
      push_exp(g % 4, 16'h0100 + 16'(g % 4), 1'b0);
      step_in();
      if (g == 4) bus.req_valid = '0;
    end
    wait_idle();

    // single read by requester 2, ack on third ISSUE cycle
    step_in();
    ack_delay = 3;
    set_req(2, 1'b0, 8'd5, 6'd8, 16'h0);
    wait_ready(r);
    check("rd_ready", {28'd0, r}, 32'h4);
    push_exp(2, 16'h00A5, 1'b0);
    step_in();
    bus.req_valid[2] = 1'b0;
    @(negedge clk);
    check("rd_ready_pulse", {28'd0, bus.req_ready}, 32'd0);
    check("rd_en_on", {31'd0, bus.mem_read_en}, 32'd1);
    check("rd_row", {24'd0, bus.mem_row}, 32'd5);
    wait_idle();
    check("rd_en_cycles", last_cycles, 32'd3);
    check("rd_row_stable", {31'd0, last_changed}, 32'd0);
    check("rd_no_write", {31'd0, last_we_seen}, 32'd0);

    // requester changes its fields right after transfer
    step_in();
    ack_delay = 4;
    set_req(0, 1'b0, 8'd7, 6'd1, 16'h0);
    wait_ready(r);
    check("chg_ready", {28'd0, r}, 32'h1);
    push_exp(0, 16'h0000, 1'b0);
    step_in();
    bus.req_row[0 +: RW] = 8'd9;
    bus.req_col[0 +: CW] = 6'd2;
    bus.req_valid[0] = 1'b0;
    wait_idle();
    check("chg_row_latched", {24'd0, last_row}, 32'd7);
    check("chg_row_stable", {31'd0, last_changed}, 32'd0);
    check("chg_en_cycles", last_cycles, 32'd4);

    // write by requester 1, then read back by requester 3
    step_in();
    ack_delay = 2;
    set_req(1, 1'b1, 8'd2, 6'd3, 16'h1234);
    wait_ready(r);
    check("wr_ready", {28'd0, r}, 32'h2);
    push_exp(1, 16'h0000, 1'b0);
    step_in();
    bus.req_valid[1] = 1'b0;
    wait_idle();
    check("wr_we_seen", {31'd0, last_we_seen}, 32'd1);
    check("wr_re_seen", {31'd0, last_re_seen}, 32'd0);
    step_in();
    ack_delay = 1;
    set_req(3, 1'b0, 8'd2, 6'd3, 16'h0);
    wait_ready(r);
    check("rb_ready", {28'd0, r}, 32'h8);
    push_exp(3, 16'h1234, 1'b0);
    step_in();
    bus.req_valid[3] = 1'b0;
    wait_idle();
    check("rb_we_seen", {31'd0, last_we_seen}, 32'd0);
    check("rb_re_seen", {31'd0, last_re_seen}, 32'd1);

    // bank never acks: watchdog fires after TO ISSUE cycles
    step_in();
    ack_delay = 0;
    set_req(0, 1'b0, 8'd4, 6'd4, 16'h0);
    wait_ready(r);
    check("to_ready", {28'd0, r}, 32'h1);
    push_exp(0, 16'h0000, 1'b1);
    step_in();
    bus.req_valid[0] = 1'b0;
    wait_idle();
    check("to_cycles", last_cycles, TO);
    check("to_sticky", {31'd0, bus.err_sticky}, 32'd1);
    step_in();
    ack_delay = 2;
    set_req(1, 1'b0, 8'd6, 6'd1, 16'h0);
    wait_ready(r);
    check("to_next_ready", {28'd0, r}, 32'h2);
    push_exp(1, 16'h0077, 1'b0);
    step_in();
    bus.req_valid[1] = 1'b0;
    wait_idle();
    check("to_sticky_hold", {31'd0, bus.err_sticky}, 32'd1);

    // reset while in ISSUE
    step_in();
    ack_delay = 0;
    set_req(3, 1'b0, 8'd1, 6'd1, 16'h0);
    wait_ready(r);
    check("mr_ready", {28'd0, r}, 32'h8);
    step_in();
    bus.req_valid[3] = 1'b0;
    @(negedge clk);
    check("mr_in_issue", {31'd0, bus.mem_read_en}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mr_read_en", {31'd0, bus.mem_read_en}, 32'd0);
    check("mr_sticky", {31'd0, bus.err_sticky}, 32'd0);
    check("mr_rsp_valid", {28'd0, bus.rsp_valid}, 32'd0);
    check("mr_rsp_data", {16'd0, bus.rsp_data}, 32'd0);
    step_in();
    step_in();
    rst = 1'b0;
    ack_delay = 1;
    set_req(1, 1'b0, 8'd6, 6'd1, 16'h0);
    set_req(3, 1'b0, 8'd12, 6'd0, 16'h0);
    wait_ready(r);
    check("mr_ptr0_grant", {28'd0, r}, 32'h2);
    push_exp(1, 16'h0077, 1'b0);
    step_in();
    bus.req_valid = '0;
    wait_idle();

    check("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
